cache_line_ctrl: RTL and testbench

// Parametrised successor of the cache controller FSM: handles multi-word line fills, a programmable memory wait and selectable write policy.

---
 rtl/cache_ctrl_pkg.sv | 59 +++++
 rtl/wait_state_ctr.sv | 33 +++
 rtl/cache_line_ctrl.sv | 150 +++++++++++++++
 tb/tb_cache_line_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the cache line controller.
//   state_t        controller FSM states
//   Out*           bit positions inside the registered output vector
//   state_outputs  Moore decode of a state into the output vector
package cache_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    READ      = 4'd1,
    WRITE     = 4'd2,
    FILL_REQ  = 4'd3,
    FILL_WAIT = 4'd4,
    FILL_WR   = 4'd5,
    RD_DONE   = 4'd6,
    WR_REQ    = 4'd7,
    WR_WAIT   = 4'd8,
    WR_DONE   = 4'd9
  } state_t;

  localparam int unsigned OutW       = 6;
  localparam int unsigned OutDReady  = 0;
  localparam int unsigned OutWe      = 1;
  localparam int unsigned OutMStrobe = 2;
  localparam int unsigned OutMrw     = 3;
  localparam int unsigned OutRSel    = 4;
  localparam int unsigned OutWSel    = 5;

  // wr_cache selects whether the final write-through also updates the cache line.
  function automatic logic [OutW-1:0] state_outputs(state_t st, logic wr_cache);
    logic [OutW-1:0] o;
    o = '0;
    case (st)
      FILL_REQ: o[OutMStrobe] = 1'b1;
      FILL_WR: begin
        o[OutWe]   = 1'b1;
        o[OutWSel] = 1'b1;
      end
      RD_DONE: o[OutDReady] = 1'b1;
      WR_REQ: begin
        o[OutMStrobe] = 1'b1;
        o[OutMrw]     = 1'b1;
        o[OutRSel]    = 1'b1;
      end
      WR_WAIT: begin
        o[OutMrw]  = 1'b1;
        o[OutRSel] = 1'b1;
      end
      WR_DONE: begin
        o[OutDReady] = 1'b1;
        o[OutMrw]    = 1'b1;
        o[OutRSel]   = 1'b1;
        o[OutWe]     = wr_cache;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/wait_state_ctr.sv
// Memory wait-state down-counter.
//   clk_i       clock, rising edge
//   reset_i     synchronous active-high reset, clears the count
//   load_i      load load_val_i (has priority over dec_i)
//   load_val_i  value to load
//   dec_i       decrement by one, saturating at zero
//   zero_o      count is zero
module wait_state_ctr #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cache_line_ctrl.sv
// Cache line controller: multi-word line fills, programmable memory wait, write-through with
// selectable write-allocate.
//   clk, reset          clock and synchronous active-high reset
//   Strobe, DRW         CPU request valid and direction (1 = write)
//   M, V                tag match and line valid for the current address
//   DReady              CPU access complete
//   W, WSel, FillWord   cache write enable, write source (1 = memory), word index in line
//   MStrobe, MRW, RSel  memory request pulse, memory direction, CPU data onto memory bus
module cache_line_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned WRITE_ALLOC = 0,
  localparam int unsigned FW_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1,
  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Strobe,
  input  logic            DRW,
  input  logic            M,
  input  logic            V,
  output logic            DReady,
  output logic            W,
  output logic            MStrobe,
  output logic            MRW,
  output logic            RSel,
  output logic            WSel,
  output logic [FW_W-1:0] FillWord
);

  localparam logic [FW_W-1:0]  LastWord = FW_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] WaitLoad = CNT_W'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [FW_W-1:0]   word_cnt_q, word_cnt_d;
  logic              hit_q, hit_d;
  logic              wpend_q, wpend_d;
  logic [OutW-1:0]   out_q, out_d;
  logic [FW_W-1:0]   fill_word_q, fill_word_d;
  logic              wait_load, wait_dec, wait_zero;

  wait_state_ctr #(
    .CNT_W(CNT_W)
  ) u_wait_ctr (
    .clk_i     (clk),
    .reset_i   (reset),
    .load_i    (wait_load),
    .load_val_i(WaitLoad),
    .dec_i     (wait_dec),
    .zero_o    (wait_zero)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    hit_d      = hit_q;
    wpend_d    = wpend_q;
    wait_load  = 1'b0;
    wait_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Strobe) state_d = DRW ? WRITE : READ;
      end
      READ: begin
        if (M && V) begin
          state_d = IDLE;
        end else begin
          word_cnt_d = '0;
          state_d    = FILL_REQ;
        end
      end
      WRITE: begin
        hit_d = M && V;
        if ((M && V) || (WRITE_ALLOC == 0)) begin
          state_d = WR_REQ;
        end else begin
          wpend_d    = 1'b1;
          word_cnt_d = '0;
          state_d    = FILL_REQ;
        end
      end
      FILL_REQ: begin
        wait_load = 1'b1;
        state_d   = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (wait_zero) state_d = FILL_WR;
        else           wait_dec = 1'b1;
      end
      FILL_WR: begin
        if (word_cnt_q == LastWord) begin
          state_d = wpend_q ? WR_REQ : RD_DONE;
        end else begin
          word_cnt_d = word_cnt_q + FW_W'(1);
          state_d    = FILL_REQ;
        end
      end
      RD_DONE: state_d = IDLE;
      WR_REQ: begin
        wait_load = 1'b1;
        state_d   = WR_WAIT;
      end
      WR_WAIT: begin
        if (wait_zero) state_d = WR_DONE;
        else           wait_dec = 1'b1;
      end
      WR_DONE: begin
        wpend_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  always_comb begin
    out_d       = state_outputs(state_d, hit_d | wpend_d);
    fill_word_d = ((state_d == FILL_REQ) || (state_d == FILL_WR)) ? word_cnt_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      hit_q       <= 1'b0;
      wpend_q     <= 1'b0;
      out_q       <= '0;
      fill_word_q <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      hit_q       <= hit_d;
      wpend_q     <= wpend_d;
      out_q       <= out_d;
      fill_word_q <= fill_word_d;
    end
  end

  // A read hit completes in READ itself, so DReady there follows M&V directly.
  assign DReady   = out_q[OutDReady] | ((state_q == READ) & M & V);
  assign W        = out_q[OutWe];
  assign MStrobe  = out_q[OutMStrobe];
  assign MRW      = out_q[OutMrw];
  assign RSel     = out_q[OutRSel];
  assign WSel     = out_q[OutWSel];
  assign FillWord = fill_word_q;

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Scoreboard bench for cache_line_ctrl. Three instances with different parameters run
// independent random request streams; each request pushes its expected timing into a queue
// and a per-instance monitor checks DUT activity against the front of that queue.
//   dut0: WAIT 4, LINE 4, no-write-allocate
//   dut1: WAIT 4, LINE 4, write-allocate
//   dut2: WAIT 1, LINE 1, no-write-allocate
module tb_cache_line_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] strobe, drw, m, v;
  logic [2:0] dready, w, mstrobe, mrw, rsel, wsel;
  logic [1:0] fw0, fw1;
  logic [0:0] fw2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  cache_line_ctrl #(.WAIT_CYCLES(4), .LINE_WORDS(4), .WRITE_ALLOC(0)) u_dut0 (
    .clk(clk), .reset(reset), .Strobe(strobe[0]), .DRW(drw[0]), .M(m[0]), .V(v[0]),
    .DReady(dready[0]), .W(w[0]), .MStrobe(mstrobe[0]), .MRW(mrw[0]), .RSel(rsel[0]),
    .WSel(wsel[0]), .FillWord(fw0)
  );

  cache_line_ctrl #(.WAIT_CYCLES(4), .LINE_WORDS(4), .WRITE_ALLOC(1)) u_dut1 (
    .clk(clk), .reset(reset), .Strobe(strobe[1]), .DRW(drw[1]), .M(m[1]), .V(v[1]),
    .DReady(dready[1]), .W(w[1]), .MStrobe(mstrobe[1]), .MRW(mrw[1]), .RSel(rsel[1]),
    .WSel(wsel[1]), .FillWord(fw1)
  );

  cache_line_ctrl #(.WAIT_CYCLES(1), .LINE_WORDS(1), .WRITE_ALLOC(0)) u_dut2 (
    .clk(clk), .reset(reset), .Strobe(strobe[2]), .DRW(drw[2]), .M(m[2]), .V(v[2]),
    .DReady(dready[2]), .W(w[2]), .MStrobe(mstrobe[2]), .MRW(mrw[2]), .RSel(rsel[2]),
    .WSel(wsel[2]), .FillWord(fw2)
  );

  typedef struct {
    int e0;   // value of cyc just after the edge that sampled Strobe
    bit wr;
    bit hit;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];
  txn_t q2[$];

  function automatic int p_wait(int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic int p_line(int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic bit p_wa(int k);
    return (k == 1);
  endfunction

  // Reference model: number of line words fetched and cycle of DReady.
  function automatic int n_fill(int k, bit wr, bit hit);
    if (!wr) return hit ? 0 : p_line(k);
    return (!hit && p_wa(k)) ? p_line(k) : 0;
  endfunction

  function automatic int exp_lat(int k, bit wr, bit hit);
    int per;
    per = p_wait(k) + 2;
    if (!wr) return hit ? 1 : 2 + p_line(k) * per;
    return 3 + p_wait(k) + n_fill(k, wr, hit) * per;
  endfunction

  function automatic int q_size(int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic txn_t q_front(int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic q_push(input int k, input txn_t t);
    case (k)
      0:       q0.push_back(t);
      1:       q1.push_back(t);
      default: q2.push_back(t);
    endcase
  endtask

  task automatic q_pop(input int k);
    case (k)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  function automatic int fw_of(int k);
    case (k)
      0:       return int'(fw0);
      1:       return int'(fw1);
      default: return int'(fw2);
    endcase
  endfunction

  task automatic chk(input string name, input int k, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s dut%0d cyc=%0d: got %0d, expected %0d", name, k, cyc, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    int packed_out;
    for (int k = 0; k < 3; k++) begin
      packed_out = (int'({dready[k], w[k], mstrobe[k], mrw[k], rsel[k], wsel[k]}) << 2)
                   | fw_of(k);
      chk(name, k, packed_out, 0);
    end
  endtask

  task automatic monitor(input int k);
    txn_t t;
    int   n, nf, lat, per;
    int   ms_cnt, w_cnt;
    ms_cnt = 0;
    w_cnt  = 0;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (q_size(k) > 0 && cyc >= q_front(k).e0) begin
        t   = q_front(k);
        n   = cyc - t.e0 + 1;
        nf  = n_fill(k, t.wr, t.hit);
        lat = exp_lat(k, t.wr, t.hit);
        per = p_wait(k) + 2;
        if (mstrobe[k]) begin
          chk("mstrobe_cycle", k, n, (ms_cnt < nf) ? 2 + ms_cnt * per : 2 + nf * per);
          chk("mstrobe_mrw", k, int'(mrw[k]), (ms_cnt < nf) ? 0 : 1);
          if (ms_cnt < nf) chk("fill_req_word", k, fw_of(k), ms_cnt);
          ms_cnt++;
        end
        if (w[k] && !dready[k]) begin
          chk("fill_wr_cycle", k, n, 1 + (w_cnt + 1) * per);
          chk("fill_wr_wsel", k, int'(wsel[k]), 1);
          chk("fill_wr_word", k, fw_of(k), w_cnt);
          w_cnt++;
        end
        if (dready[k]) begin
          chk("dready_latency", k, n, lat);
          chk("mstrobe_count", k, ms_cnt, nf + int'(t.wr));
          chk("fill_count", k, w_cnt, nf);
          chk("done_w", k, int'(w[k]), int'(t.wr && (t.hit || nf > 0)));
          chk("done_wsel", k, int'(wsel[k]), 0);
          chk("done_mrw", k, int'(mrw[k]), int'(t.wr));
          chk("done_rsel", k, int'(rsel[k]), int'(t.wr));
          q_pop(k);
          ms_cnt = 0;
          w_cnt  = 0;
        end else if (n > lat + 2) begin
          chk("dready_by_deadline", k, int'(dready[k]), 1);
          q_pop(k);
          ms_cnt = 0;
          w_cnt  = 0;
        end
      end else begin
        chk("idle_dready", k, int'(dready[k]), 0);
      end
    end
  endtask

  // Called at posedge+1 with the instance idle; returns the same way.
  task automatic run_txns(input int k, input int count);
    bit   wr, hit;
    int   lat, gap, sel;
    txn_t t;
    for (int i = 0; i < count; i++) begin
      wr  = 1'($urandom);
      hit = 1'($urandom);
      if (hit) begin
        m[k] = 1'b1;
        v[k] = 1'b1;
      end else begin
        sel  = $urandom_range(0, 2);
        m[k] = (sel == 1);
        v[k] = (sel == 2);
      end
      drw[k]    = wr;
      strobe[k] = 1'b1;
      t.e0  = cyc + 1;
      t.wr  = wr;
      t.hit = hit;
      q_push(k, t);
      lat = exp_lat(k, wr, hit);
      @(posedge clk); #1;
      // Cycle 1: M/V still held for the hit decision; Strobe/DRW noise must be ignored.
      strobe[k] = 1'($urandom);
      drw[k]    = 1'($urandom);
      for (int c = 2; c <= lat; c++) begin
        @(posedge clk); #1;
        strobe[k] = 1'($urandom);
        drw[k]    = 1'($urandom);
        m[k]      = 1'($urandom);
        v[k]      = 1'($urandom);
      end
      @(posedge clk); #1;
      strobe[k] = 1'b0;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
        m[k] = 1'($urandom);
        v[k] = 1'($urandom);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none
  end

  initial begin
    txn_t t;
    reset  = 1'b1;
    strobe = '0;
    drw    = '0;
    m      = '0;
    v      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk); #1;
    reset = 1'b0;

    fork
      run_txns(0, 40);
      run_txns(1, 40);
      run_txns(2, 40);
    join
    @(posedge clk); #1;

    // Read miss on every instance, reset asserted during cycle 4: no DReady may follow.
    strobe = 3'b111;
    drw    = '0;
    m      = '0;
    v      = '0;
    @(posedge clk); #1;
    strobe = '0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset_outputs");

    // A read hit straight after the aborted access must answer in cycle 1.
    @(posedge clk); #1;
    strobe = 3'b111;
    m      = 3'b111;
    v      = 3'b111;
    for (int k = 0; k < 3; k++) begin
      t.e0  = cyc + 1;
      t.wr  = 1'b0;
      t.hit = 1'b1;
      q_push(k, t);
    end
    @(posedge clk); #1;
    strobe = '0;
    repeat (3) begin @(posedge clk); #1; end

    fork
      run_txns(0, 15);
      run_txns(1, 15);
      run_txns(2, 15);
    join
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
